// File: rtl/u_shift_if.sv
// Bus bundle for the universal shift register: parallel/serial inputs, op select
// and the registered contents.
interface u_shift_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] a;
  logic [1:0]       sel;
  logic             bsRight;
  logic             bsLeft;
  logic [WIDTH-1:0] a_shifted;

  modport master (
    output a, sel, bsRight, bsLeft,
    input  a_shifted
  );

  modport slave (
    input  a, sel, bsRight, bsLeft,
    output a_shifted
  );
endinterface

// File: rtl/u_shift.sv
// Universal shift register (hold / shift right / shift left / load), built from
// one 4:1 selector and one async-reset flip-flop per bit.
module mux (
  input  logic [1:0] sel,
  input  logic [3:0] d,
  output logic       out
);
  assign out = d[sel];
endmodule

module dff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) q <= 1'b0;
    else       q <= d;
  end
endmodule

module u_shift #(
  parameter int WIDTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  u_shift_if.slave   bus
);
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] d_next;
  logic [WIDTH-1:0] right_src;
  logic [WIDTH-1:0] left_src;

  // Neighbour taps; the serial inputs fill the bit vacated at each end.
  assign right_src = {bus.bsRight, q[WIDTH-1:1]};
  assign left_src  = {q[WIDTH-2:0], bus.bsLeft};

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    mux u_mux (
      .sel (bus.sel),
      .d   ({bus.a[i], left_src[i], right_src[i], q[i]}),
      .out (d_next[i])
    );
    dff u_dff (
      .clk   (clk),
      .reset (reset),
      .d     (d_next[i]),
      .q     (q[i])
    );
  end

  assign bus.a_shifted = q;
endmodule

// File: tb/tb_u_shift.sv
// Directed bench for u_shift (WIDTH=8) with a behavioural reference model.
module tb_u_shift;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  logic [7:0] mdl = 8'h00;

  u_shift_if #(.WIDTH(8)) bus ();

  u_shift #(.WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model: operation semantics expressed arithmetically.
  always @(posedge clk) begin
    if (reset) mdl = 8'h00;
    else begin
      case (bus.sel)
        2'b00: mdl = mdl;
        2'b01: mdl = (mdl >> 1) + (bus.bsRight ? 8'd128 : 8'd0);
        2'b10: mdl = (mdl << 1) + (bus.bsLeft ? 8'd1 : 8'd0);
        default: mdl = bus.a;
      endcase
    end
  end

  always @(posedge reset) mdl = 8'h00;

  // Compare against the model every cycle, away from the active edge.
  always @(negedge clk) begin
    if (reset !== 1'bx) begin
      checks++;
      if (bus.a_shifted !== mdl) begin
        errors++;
        $display("FAIL model_cmp t=%0t actual=%b expected=%b", $time, bus.a_shifted, mdl);
      end
    end
  end

  task automatic check(input string name, input logic [7:0] exp);
    checks++;
    if (bus.a_shifted !== exp) begin
      errors++;
      $display("FAIL %s actual=%b expected=%b", name, bus.a_shifted, exp);
    end
  endtask

  task automatic op(input logic [1:0] s, input logic [7:0] av, input logic br, input logic bl);
    @(negedge clk);
    bus.sel = s; bus.a = av; bus.bsRight = br; bus.bsLeft = bl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    bus.a = 8'b1011_0011; bus.sel = 2'b11; bus.bsRight = 1'b0; bus.bsLeft = 1'b0;
    #1;
    check("reset_immediate", 8'h00);
    @(posedge clk); #1;
    check("reset_hold1", 8'h00);
    @(posedge clk); #1;
    check("reset_hold2", 8'h00);

    // 1. release reset, load on the next edge
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    check("load_after_reset", 8'b1011_0011);

    // 2. hold while toggling other inputs, including mid-cycle changes
    op(2'b00, 8'h5A, 1'b1, 1'b0); check("hold1", 8'b1011_0011);
    op(2'b00, 8'hA5, 1'b0, 1'b1); check("hold2", 8'b1011_0011);
    @(negedge clk); bus.a = 8'hFF; bus.bsRight = 1'b1;
    #2 bus.a = 8'h00; bus.bsLeft = 1'b0;
    @(posedge clk); #1;
    check("hold3", 8'b1011_0011);

    // 3. shift right
    op(2'b01, 8'h00, 1'b1, 1'b0); check("shr_in1", 8'b1101_1001);
    op(2'b01, 8'hFF, 1'b0, 1'b1); check("shr_in0_bsleft_ignored", 8'b0110_1100);

    // 4. shift left from 11011001, then shift out completely
    op(2'b11, 8'b1101_1001, 1'b0, 1'b0); check("reload_d9", 8'b1101_1001);
    op(2'b10, 8'h00, 1'b1, 1'b1); check("shl_in1", 8'b1011_0011);
    op(2'b10, 8'h00, 1'b1, 1'b0); check("shl_bsright_ignored", 8'b0110_0110);
    for (int i = 0; i < 7; i++) op(2'b10, 8'h00, 1'b0, 1'b0);
    check("shl_drain", 8'h00);

    // 5. reload and mixed ops
    op(2'b11, 8'b1111_0000, 1'b0, 1'b0); check("load_f0", 8'b1111_0000);
    op(2'b10, 8'h00, 1'b0, 1'b1); check("mixed_shl", 8'b1110_0001);
    op(2'b01, 8'h00, 1'b0, 1'b0); check("mixed_shr", 8'b0111_0000);

    // 6. asynchronous reset pulse between edges
    op(2'b11, 8'b1111_0000, 1'b0, 1'b0); check("load_f0_again", 8'b1111_0000);
    @(negedge clk);
    bus.sel = 2'b11; bus.a = 8'b0101_0101;
    #1 reset = 1'b1;
    #1 check("async_reset", 8'h00);
    #1 reset = 1'b0;
    #1 check("after_release_before_edge", 8'h00);
    @(posedge clk); #1;
    check("load_55", 8'b0101_0101);

    // chained right shifts: 4 cycles shift by 4
    for (int i = 0; i < 4; i++) op(2'b01, 8'h00, 1'b0, 1'b0);
    check("shr_by4", 8'b0000_0101);

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/u_shift.md
# u_shift

Parameterisable universal shift register: a bank of D flip-flops, each fed by a 4:1 selector, supporting hold, shift right, shift left and parallel load. It is the shift/rotate storage element of the ALU datapath. Its registered output feeds the ALU result path and can be re-fed by the ALU to its own parallel input. The block is built structurally from two leaf cells: `mux` (4:1, 1-bit) and `dff` (1-bit, async reset).

## Interface

**Parameters**
- `WIDTH`, default 8: register width in bits; must be ≥ 2.

**Ports**
- `clk`: input, 1 bit. Single clock; all state updates on the rising edge.
- `reset`: input, 1 bit. Asynchronous, active-high; clears the register.
- `a`: input, WIDTH bits. Parallel load data.
- `sel`: input, 2 bits. Operation select.
- `bsRight`: input, 1 bit. Serial input for right shift; enters the MSB.
- `bsLeft`: input, 1 bit. Serial input for left shift; enters the LSB.
- `a_shifted`: output, WIDTH bits. Register contents (Q of the flip-flops), driven directly with no combinational path from the inputs.

**Leaf cells**
- `mux`: ports `sel[1:0]`, `d[3:0]`, `out`. Function: `out = d[sel]`, purely combinational.
- `dff`: ports `clk`, `reset`, `d`, `q`.
  - `q` clears to 0 asynchronously while `reset` = 1.
  - Otherwise `q <= d` on the rising edge of `clk`.

## Operation

Let Q = `a_shifted`, sampled at the rising edge of `clk`. Bit *i* has its own `mux`, with inputs wired as `d = {a[i], left_src, right_src, Q[i]}`.

**sel encoding**
- `00`, hold: Q unchanged.
- `01`, shift right: Q ← {bsRight, Q[WIDTH-1:1]}. Q[0] is discarded.
- `10`, shift left: Q ← {Q[WIDTH-2:0], bsLeft}. Q[WIDTH-1] is discarded.
- `11`, parallel load: Q ← a.

**Rules**
- Only the values of `sel`, `a`, `bsRight` and `bsLeft` present at the clock edge matter. Changes between edges have no effect on Q.
- The serial inputs are ignored except in their own shift mode: `bsRight` only in `01`, `bsLeft` only in `10`.
- No arithmetic and no sign extension. Sign-extending or rotating behaviour is obtained externally by driving `bsRight`/`bsLeft` from Q.
- There are no status outputs and no handshake.

## Timing

- **Reset:** `a_shifted` = 0 immediately on `reset` rising, independent of `clk`. It stays 0 for as long as `reset` is high, whatever `sel` is.
- **Reset release:** the first update happens on the first rising `clk` edge with `reset` low.
- **Reset asserted mid-operation:** any shift or load in progress is abandoned and Q goes to 0 at once. There is no pending-operation memory.
- **Latency:** 1 cycle. The operation selected at edge *n* is visible on `a_shifted` just after edge *n*.
- **Throughput:** one operation per cycle. Back-to-back shifts chain, so *k* cycles of `sel = 01` shift right by *k*.
- **Combinational path:** Q → mux → D feedback only. The output carries no combinational dependence on inputs.

## Test plan

All cases use WIDTH = 8.

1. **Reset and load.** Hold `reset` = 1 with `a` = 10110011, `sel` = 11 → `a_shifted` = 00000000 throughout reset. Release `reset` → `a_shifted` = 10110011 after the next rising edge.
2. **Hold.** From Q = 10110011, apply `sel` = 00 for 3 cycles while toggling `a`, `bsLeft` and `bsRight` → Q stays 10110011.
3. **Shift right.** From Q = 10110011, `sel` = 01, `bsRight` = 1 → 11011001. A following cycle with `bsRight` = 0 → 01101100.
4. **Shift left.** From Q = 11011001, `sel` = 10, `bsLeft` = 1 → 10110011. Then 8 more cycles with `bsLeft` = 0 → 00000000.
5. **Reload and mixed ops.** `sel` = 11, `a` = 11110000 → 11110000. Then `sel` = 10, `bsLeft` = 1 → 11100001. Then `sel` = 01, `bsRight` = 0 → 01110000.
6. **Asynchronous reset mid-clock.** With Q = 11110000, pulse `reset` high between clock edges → Q = 00000000 before the next edge. After release, a load with `a` = 01010101 → 01010101 one edge later.
